// File: rtl/record_framer.sv
// record_framer: frames a raw ADC sample stream into records.
// A record starts with a one-cycle o_new_record pulse, then emits exactly
// the latched record length of decimated samples (1 of every decim valid
// inputs), and finishes with o_done coinciding with the last sample.
// All outputs are registered; i_ce gates every state update.
module record_framer #(
    parameter int DATA_WIDTH = 11,
    parameter int LEN_WIDTH  = 24,
    parameter int DEC_WIDTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_ce,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [LEN_WIDTH-1:0]  i_record_len,
    input  logic [DEC_WIDTH-1:0]  i_decim,
    input  logic [DATA_WIDTH-1:0] i_adc_data,
    input  logic                  i_adc_valid,
    output logic                  o_new_record,
    output logic                  o_signal_valid,
    output logic [DATA_WIDTH-1:0] o_signal,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [LEN_WIDTH-1:0]    len_reg, len_next;
    logic [DEC_WIDTH-1:0]    decim_reg, decim_next;
    logic [DEC_WIDTH-1:0]    dec_cnt_reg, dec_cnt_next;
    logic [LEN_WIDTH-1:0]    emit_cnt_reg, emit_cnt_next;
    logic [DATA_WIDTH-1:0]   signal_reg, signal_next;
    logic                    new_record_reg, new_record_next;
    logic                    signal_valid_reg, signal_valid_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;
    logic                    overrun_reg, overrun_next;

    // Helper values: last decimation phase and the post-emit sample count.
    logic [DEC_WIDTH-1:0]    decim_last;
    logic [LEN_WIDTH-1:0]    emit_cnt_inc;

    assign decim_last   = decim_reg - DEC_WIDTH'(1);
    assign emit_cnt_inc = emit_cnt_reg + LEN_WIDTH'(1);

    // State and output registers; async reset clears everything at once.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_reg        <= ST_IDLE;
            len_reg          <= '0;
            decim_reg        <= '0;
            dec_cnt_reg      <= '0;
            emit_cnt_reg     <= '0;
            signal_reg       <= '0;
            new_record_reg   <= 1'b0;
            signal_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            len_reg          <= len_next;
            decim_reg        <= decim_next;
            dec_cnt_reg      <= dec_cnt_next;
            emit_cnt_reg     <= emit_cnt_next;
            signal_reg       <= signal_next;
            new_record_reg   <= new_record_next;
            signal_valid_reg <= signal_valid_next;
            busy_reg         <= busy_next;
            done_reg         <= done_next;
            overrun_reg      <= overrun_next;
        end
    end

    // Next-state logic: everything holds and pulses drop unless i_ce is high.
    always_comb begin
        state_next        = state_reg;
        len_next          = len_reg;
        decim_next        = decim_reg;
        dec_cnt_next      = dec_cnt_reg;
        emit_cnt_next     = emit_cnt_reg;
        signal_next       = signal_reg;
        overrun_next      = overrun_reg;
        new_record_next   = 1'b0;
        signal_valid_next = 1'b0;
        done_next         = 1'b0;

        if (i_ce) begin
            case (state_reg)
                ST_IDLE: begin
                    // Abort in the same cycle suppresses the start entirely.
                    if (i_start && !i_abort && (i_record_len != '0)) begin
                        len_next        = i_record_len;
                        decim_next      = (i_decim == '0) ? DEC_WIDTH'(1) : i_decim;
                        dec_cnt_next    = '0;
                        emit_cnt_next   = '0;
                        overrun_next    = 1'b0;
                        new_record_next = 1'b1;
                        state_next      = ST_START;
                    end
                end
                ST_START: begin
                    // Samples during the announce cycle are dropped.
                    state_next = i_abort ? ST_IDLE : ST_RUN;
                end
                ST_RUN: begin
                    if (i_abort) begin
                        state_next = ST_IDLE;
                    end else if (i_adc_valid) begin
                        if (dec_cnt_reg == decim_last) begin
                            dec_cnt_next      = '0;
                            signal_next       = i_adc_data;
                            signal_valid_next = 1'b1;
                            emit_cnt_next     = emit_cnt_inc;
                            if (emit_cnt_inc == len_reg) begin
                                done_next  = 1'b1;
                                state_next = ST_DONE;
                            end
                        end else begin
                            dec_cnt_next = dec_cnt_reg + DEC_WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase

            // A start request while a record is in flight is only flagged.
            if ((state_reg != ST_IDLE) && i_start) begin
                overrun_next = 1'b1;
            end
        end

        busy_next = (state_next != ST_IDLE);
    end

    assign o_new_record   = new_record_reg;
    assign o_signal_valid = signal_valid_reg;
    assign o_signal       = signal_reg;
    assign o_busy         = busy_reg;
    assign o_done         = done_reg;
    assign o_overrun      = overrun_reg;

endmodule
